// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle table (degrees, Q16.16), gain, fold limits.
// Latency: none (package only).
// Backpressure: not applicable.
package cordic_pkg;

  localparam int CORDIC_W      = 32;
  localparam int CORDIC_STAGES = 16;

  // Inverse CORDIC gain, 0.60725 in Q16.16, preloaded into x so the result is unit-scaled
  localparam logic signed [CORDIC_W-1:0] CORDIC_K = 32'sh0000_9B74;

  localparam logic signed [CORDIC_W-1:0] DEG90  = 32'sd5898240;
  localparam logic signed [CORDIC_W-1:0] DEG180 = 32'sd11796480;

  // atan(2^-i) in degrees x 2^16, shared with the vectoring-mode arctan core
  localparam logic signed [CORDIC_W-1:0] ATAN_TAB [0:CORDIC_STAGES-1] = '{
    32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
    32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
    32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
    32'sd896,     32'sd448,     32'sd256,    32'sd128
  };

  typedef struct packed {
    logic [CORDIC_W-1:0] z;
    logic                neg;
  } cordic_fold_t;

  // Map |angle| > 90 deg onto the opposite quadrant; the result is negated at the output
  function automatic cordic_fold_t cordic_fold(input logic signed [CORDIC_W-1:0] a);
    cordic_fold_t f;
    if (a > DEG90) begin
      f.z   = a - DEG180;
      f.neg = 1'b1;
    end else if (a < -DEG90) begin
      f.z   = a + DEG180;
      f.neg = 1'b1;
    end else begin
      f.z   = a;
      f.neg = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One rotation-mode CORDIC micro-rotation by +/-atan(2^-SHIFT), fully registered.
// Latency: 1 cycle.
// Backpressure: none; advances every cycle, neg/v flags ride along with the data.
module cordic_rot_stage
  import cordic_pkg::*;
#(
  parameter int W     = CORDIC_W,
  parameter int SHIFT = 0
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic signed [W-1:0] i_atan,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  input  logic signed [W-1:0] i_z,
  input  logic                i_neg,
  input  logic                i_v,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output logic signed [W-1:0] o_z,
  output logic                o_neg,
  output logic                o_v
);

  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_z;
  logic                r_neg;
  logic                r_v;
  logic signed [W-1:0] w_x_sh;
  logic signed [W-1:0] w_y_sh;

  assign w_x_sh = i_x >>> SHIFT;
  assign w_y_sh = i_y >>> SHIFT;

  // Rotate toward z = 0: positive residual rotates counter-clockwise, negative clockwise
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_neg <= 1'b0;
      r_v   <= 1'b0;
    end else begin
      if (!i_z[W-1]) begin
        r_x <= i_x - w_y_sh;
        r_y <= i_y + w_x_sh;
        r_z <= i_z - i_atan;
      end else begin
        r_x <= i_x + w_y_sh;
        r_y <= i_y - w_x_sh;
        r_z <= i_z + i_atan;
      end
      r_neg <= i_neg;
      r_v   <= i_v;
    end
  end

  assign o_x   = r_x;
  assign o_y   = r_y;
  assign o_z   = r_z;
  assign o_neg = r_neg;
  assign o_v   = r_v;

endmodule

// File: rtl/cordic_sincos.sv
// Pipelined rotation-mode CORDIC: Q16.16 degrees in, Q16.16 cos/sin out. Option: CORDIC_FULL_RANGE_EN (+/-180 deg fold).
// Latency: 17 cycles from sampling edge to out_valid (fold + 16 iterations + output register).
// Backpressure: none; one angle accepted per cycle, bubbles propagate as out_valid=0.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int W      = CORDIC_W,
  parameter int STAGES = CORDIC_STAGES
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [W-1:0] angle,
  output logic                out_valid,
  output logic signed [W-1:0] cos_out,
  output logic signed [W-1:0] sin_out
);

  cordic_fold_t        w_fold;
  logic signed [W-1:0] r_f_x;
  logic signed [W-1:0] r_f_y;
  logic signed [W-1:0] r_f_z;
  logic                r_f_neg;
  logic                r_f_v;

  logic signed [W-1:0] w_x   [0:STAGES];
  logic signed [W-1:0] w_y   [0:STAGES];
  logic signed [W-1:0] w_z   [0:STAGES];
  logic                w_neg [0:STAGES];
  logic                w_v   [0:STAGES];

  logic                r_out_vld;
  logic signed [W-1:0] r_cos;
  logic signed [W-1:0] r_sin;
  logic                w_unused;

  // Bring the angle into the +/-90 deg convergence range of the iterations
  always_comb begin
`ifdef CORDIC_FULL_RANGE_EN
    w_fold = cordic_fold(angle);
`else
    w_fold.z   = angle;
    w_fold.neg = 1'b0;
`endif
  end

  // Fold stage: seed x with the gain so the rotated vector lands on the unit circle
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_f_x   <= '0;
      r_f_y   <= '0;
      r_f_z   <= '0;
      r_f_neg <= 1'b0;
      r_f_v   <= 1'b0;
    end else begin
      r_f_x   <= CORDIC_K;
      r_f_y   <= '0;
      r_f_z   <= w_fold.z;
      r_f_neg <= w_fold.neg;
      r_f_v   <= in_valid;
    end
  end

  assign w_x[0]   = r_f_x;
  assign w_y[0]   = r_f_y;
  assign w_z[0]   = r_f_z;
  assign w_neg[0] = r_f_neg;
  assign w_v[0]   = r_f_v;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_rot_stage #(
      .W     (W),
      .SHIFT (i)
    ) u_stage (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .i_atan  (ATAN_TAB[i]),
      .i_x     (w_x[i]),
      .i_y     (w_y[i]),
      .i_z     (w_z[i]),
      .i_neg   (w_neg[i]),
      .i_v     (w_v[i]),
      .o_x     (w_x[i+1]),
      .o_y     (w_y[i+1]),
      .o_z     (w_z[i+1]),
      .o_neg   (w_neg[i+1]),
      .o_v     (w_v[i+1])
    );
  end

  // Output register: capture only valid samples so bubbles leave the last result in place
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_cos     <= '0;
      r_sin     <= '0;
    end else begin
      r_out_vld <= w_v[STAGES];
      if (w_v[STAGES]) begin
`ifdef CORDIC_FULL_RANGE_EN
        r_cos <= w_neg[STAGES] ? -w_x[STAGES] : w_x[STAGES];
        r_sin <= w_neg[STAGES] ? -w_y[STAGES] : w_y[STAGES];
`else
        r_cos <= w_x[STAGES];
        r_sin <= w_y[STAGES];
`endif
      end
    end
  end

  // The residual angle after the last iteration has no consumer
`ifdef CORDIC_FULL_RANGE_EN
  assign w_unused = ^w_z[STAGES];
`else
  assign w_unused = ^{w_z[STAGES], w_neg[STAGES]};
`endif

  assign out_valid = r_out_vld;
  assign cos_out   = r_cos;
  assign sin_out   = r_sin;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed + random check of cordic_sincos against a real-arithmetic trig model.
// Latency expectation: result of the input sampled at edge k is visible after edge k+17.
// Backpressure: none; the bench drives an input (or a bubble) every cycle.
module tb_cordic_sincos;

  localparam int LAT = 17;
  localparam int TOL = 64;
  localparam int D1  = 65536;

  logic               clk_50M = 1'b0;
  logic               rst_n   = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] angle   = '0;
  logic               out_valid;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;

  int n_cmp = 0;
  int n_bad = 0;

  // History of what was presented at each sampling edge (index = edge number)
  logic               hist_v [0:4095];
  logic signed [31:0] hist_a [0:4095];
  int                 cyc = 0;
  logic               have = 1'b0;
  logic               exp_v = 1'b0;
  logic signed [31:0] exp_a = '0;

  cordic_sincos dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .angle     (angle),
    .out_valid (out_valid),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic int ref_trig(input logic signed [31:0] a, input bit is_sin);
    real rad;
    real r;
    rad = ($itor(a) / 65536.0) * 3.14159265358979 / 180.0;
    r   = is_sin ? $sin(rad) : $cos(rad);
    r   = r * 65536.0;
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction

  task automatic check_outputs(input string tag);
    int ec;
    int es;
    int dc;
    int ds;
    n_cmp++;
    assert (out_valid === exp_v) else begin
      n_bad++;
      $error("FAIL %s out_valid edge=%0d got=%b exp=%b", tag, cyc, out_valid, exp_v);
    end
    if (have) begin
      ec = ref_trig(exp_a, 1'b0);
      es = ref_trig(exp_a, 1'b1);
      dc = int'(cos_out) - ec;
      ds = int'(sin_out) - es;
      n_cmp++;
      assert (!$isunknown(cos_out) && dc >= -TOL && dc <= TOL) else begin
        n_bad++;
        $error("FAIL %s cos edge=%0d angle=%0d got=%0d exp=%0d", tag, cyc, exp_a, cos_out, ec);
      end
      n_cmp++;
      assert (!$isunknown(sin_out) && ds >= -TOL && ds <= TOL) else begin
        n_bad++;
        $error("FAIL %s sin edge=%0d angle=%0d got=%0d exp=%0d", tag, cyc, exp_a, sin_out, es);
      end
    end else begin
      n_cmp++;
      assert (cos_out === 32'sd0) else begin
        n_bad++;
        $error("FAIL %s cos_reset edge=%0d got=%0d exp=0", tag, cyc, cos_out);
      end
      n_cmp++;
      assert (sin_out === 32'sd0) else begin
        n_bad++;
        $error("FAIL %s sin_reset edge=%0d got=%0d exp=0", tag, cyc, sin_out);
      end
    end
  endtask

  // Present one input for one clock, then check the outputs just after the edge
  task automatic tick(input logic v, input logic signed [31:0] a, input string tag);
    in_valid    = v;
    angle       = a;
    hist_v[cyc] = v && rst_n;
    hist_a[cyc] = a;
    @(posedge clk_50M);
    #1;
    if (cyc >= LAT && hist_v[cyc-LAT]) begin
      exp_v = 1'b1;
      exp_a = hist_a[cyc-LAT];
      have  = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    cyc++;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(1'b0, $urandom, tag);
  endtask

  task automatic one(input logic signed [31:0] a, input string tag);
    tick(1'b1, a, tag);
    idle(LAT + 1, tag);
  endtask

  function automatic logic signed [31:0] rand_angle();
`ifdef CORDIC_FULL_RANGE_EN
    return int'($urandom_range(0, 23592960)) - 11796480;
`else
    return int'($urandom_range(0, 11796480)) - 5898240;
`endif
  endfunction

  initial begin
    // Reset state
    #1;
    check_outputs("reset_init");
    idle(3, "in_reset");
    rst_n = 1'b1;
    idle(2, "post_reset");

    // Directed angles inside the base range
    one(32'sd0,          "zero");
    one(32'sd1966080,    "deg30");
    one(-32'sd2949120,   "deg_m45");
    one(32'sd5898240,    "deg90");
    one(-32'sd5898240,   "deg_m90");

`ifdef CORDIC_FULL_RANGE_EN
    one(32'sd9830400,    "deg150");
    one(-32'sd11796480,  "deg_m180");
    one(32'sd11796480,   "deg180");
    one(32'sd5898241,    "fold_edge_p");
    one(-32'sd5898241,   "fold_edge_m");
    one(-32'sd8847360,   "deg_m135");
`endif

    // Streaming run with a 3-cycle bubble in the middle
    for (int k = 0; k < 20; k++) begin
      if (k == 10) idle(3, "stream_bubble");
      tick(1'b1, (-50 + 5 * k) * D1, "stream");
    end
    idle(LAT + 2, "stream_drain");

    // Hold: one result, then a long run of bubbles carrying garbage angles
    tick(1'b1, 32'sd1966080, "hold_src");
    idle(LAT + 40, "hold");

    // Reset while 8 samples are in flight
    for (int k = 0; k < 8; k++) tick(1'b1, rand_angle(), "pre_rst");
    #4;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < cyc; k++) hist_v[k] = 1'b0;
    have  = 1'b0;
    exp_v = 1'b0;
    check_outputs("rst_async");
    idle(3, "rst_held");
    rst_n = 1'b1;
    idle(LAT + 5, "rst_no_spurious");
    one(-32'sd2949120, "rst_first");

    // Random traffic with random bubbles
    for (int k = 0; k < 300; k++) begin
      tick(($urandom_range(0, 3) != 0), rand_angle(), "random");
    end
    idle(LAT + 2, "random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
